ring_draw_sched: RTL

- Sequencer that shares one VGA plot port between the fillscreen engine and the circle engine.
- On start: clears the screen with fillscreen, then draws `count` concentric circles about (centre_x, centre_y). Ring i has radius base_radius + i*step.
- Drives each engine with the team's start/done handshake and muxes the engine's VGA outputs onto the adapter.
- Sits between the top-level task wrapper and the two engines.

---
 rtl/ring_draw_sched.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ring_draw_sched.sv
// Clears the screen with the fillscreen engine, then draws concentric rings with the circle engine on one shared VGA port.
// Build option: define RING_COLOUR_CYCLE_EN to colour ring i as (i mod 7)+1 instead of using the colour input.
module ring_draw_sched #(
  parameter int MAX_RINGS = 15,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             done,
  input  logic [2:0]       colour,
  input  logic [7:0]       centre_x,
  input  logic [6:0]       centre_y,
  input  logic [7:0]       base_radius,
  input  logic [7:0]       step,
  input  logic [CNT_W-1:0] count,
  output logic             fill_start,
  input  logic             fill_done,
  input  logic [7:0]       fill_vga_x,
  input  logic [6:0]       fill_vga_y,
  input  logic [2:0]       fill_vga_colour,
  input  logic             fill_vga_plot,
  output logic             circ_start,
  input  logic             circ_done,
  output logic [2:0]       circ_colour,
  output logic [7:0]       circ_centre_x,
  output logic [6:0]       circ_centre_y,
  output logic [7:0]       circ_radius,
  input  logic [7:0]       circ_vga_x,
  input  logic [6:0]       circ_vga_y,
  input  logic [2:0]       circ_vga_colour,
  input  logic             circ_vga_plot,
  output logic [7:0]       vga_x,
  output logic [6:0]       vga_y,
  output logic [2:0]       vga_colour,
  output logic             vga_plot,
  output logic [2:0]       dbg_state
);

  // Handshake (both directions): the requester holds start high until it sees done high,
  // then drops start; the responder holds done high until it sees start low.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_FILL_REL = 3'd2,
    S_CIRC     = 3'd3,
    S_CIRC_REL = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RINGS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic [7:0]       cx_q, cx_d, step_q, step_d, radius_q, radius_d;
  logic [6:0]       cy_q, cy_d;
  logic [2:0]       col_q, col_d;
  logic [8:0]       next_radius;
  logic [CNT_W:0]   idx_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      col_q    <= '0;
      step_q   <= '0;
      radius_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      col_q    <= col_d;
      step_q   <= step_d;
      radius_q <= radius_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    col_d       = col_q;
    step_d      = step_q;
    radius_d    = radius_q;
    next_radius = {1'b0, radius_q} + {1'b0, step_q};
    idx_inc     = {1'b0, idx_q} + {{CNT_W{1'b0}}, 1'b1};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d     = centre_x;
          cy_d     = centre_y;
          step_d   = step;
          radius_d = base_radius;
          cnt_d    = (count > MAX_C) ? MAX_C : count;
          idx_d    = '0;
`ifdef RING_COLOUR_CYCLE_EN
          col_d    = 3'd1;
`else
          col_d    = colour;
`endif
          state_d  = S_FILL;
        end
      end
      S_FILL:     if (fill_done) state_d = S_FILL_REL;
      S_FILL_REL: if (!fill_done) state_d = (cnt_q != '0) ? S_CIRC : S_DONE;
      S_CIRC:     if (circ_done) state_d = S_CIRC_REL;
      S_CIRC_REL: begin
        if (!circ_done) begin
          idx_d = idx_inc[CNT_W-1:0];
          // A ring whose radius would pass 255 ends the sequence instead of wrapping.
          if ((idx_inc < {1'b0, cnt_q}) && !next_radius[8]) begin
            state_d  = S_CIRC;
            radius_d = next_radius[7:0];
`ifdef RING_COLOUR_CYCLE_EN
            col_d    = (col_q == 3'd7) ? 3'd1 : col_q + 3'd1;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:     if (!start) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state_q)
      S_FILL, S_FILL_REL: begin
        vga_x      = fill_vga_x;
        vga_y      = fill_vga_y;
        vga_colour = fill_vga_colour;
        vga_plot   = fill_vga_plot;
      end
      S_CIRC, S_CIRC_REL: begin
        vga_x      = circ_vga_x;
        vga_y      = circ_vga_y;
        vga_colour = circ_vga_colour;
        vga_plot   = circ_vga_plot;
      end
      default: ;
    endcase
  end

  assign done          = (state_q == S_DONE);
  assign fill_start    = (state_q == S_FILL);
  assign circ_start    = (state_q == S_CIRC);
  assign circ_colour   = col_q;
  assign circ_centre_x = cx_q;
  assign circ_centre_y = cy_q;
  assign circ_radius   = radius_q;
  assign dbg_state     = state_q;

endmodule
